// File: rtl/snn_pkg.sv
// Shared SNN front-end types: encoder FSM states and datapath widths.
package snn_pkg;

    localparam int unsigned RAND_W = 8;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned INT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/poisson_spike_encoder_if.sv
// Spike event stream from the encoder to the LIF array (valid/ready handshake).
interface poisson_spike_encoder_if
    import snn_pkg::*;
#(
    parameter int unsigned CH_W = 4
) ();

    logic              spk_valid;
    logic              spk_ready;
    logic [CH_W-1:0]   spk_ch;
    logic [STEP_W-1:0] spk_step;

    modport master (
        output spk_valid,
        output spk_ch,
        output spk_step,
        input  spk_ready
    );

    modport slave (
        input  spk_valid,
        input  spk_ch,
        input  spk_step,
        output spk_ready
    );

endinterface

// File: rtl/intensity_regfile.sv
// Per-channel spike intensity storage: one synchronous write port, one async read port.
module intensity_regfile
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CH_W-1:0]  waddr,
    input  logic [INT_W-1:0] wdata,
    input  logic [CH_W-1:0]  raddr,
    output logic [INT_W-1:0] rdata_c
);

    logic [INT_W-1:0] mem [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/poisson_spike_encoder.sv
// Rate-codes NUM_CH intensities into a spike event stream, one channel evaluated per cycle.
// Optional build macro POISSON_REFRACTORY_EN blocks a channel for one step after it spikes.
module poisson_spike_encoder
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RAND_W-1:0]       rand_in,
    input  logic                    cfg_wr_en,
    input  logic [CH_W-1:0]         cfg_addr,
    input  logic [INT_W-1:0]        cfg_data,
    input  logic                    start,
    input  logic [STEP_W-1:0]       num_steps,
    output logic                    busy,
    output logic                    done,
    poisson_spike_encoder_if.master spk
);

    enc_state_e        state;
    enc_state_e        state_nxt;
    logic [CH_W-1:0]   ch_ptr;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] last_step;
    logic [INT_W-1:0]  rd_int;
    logic              start_acc;
    logic              slot_free;
    logic              eval_en;
    logic              last_ch;
    logic              raw_hit;
    logic              hit;

    intensity_regfile #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_wr_en && (state == IDLE)),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .raddr   (ch_ptr),
        .rdata_c (rd_int)
    );

    assign raw_hit = (rand_in < rd_int);

`ifdef POISSON_REFRACTORY_EN
    // Each channel is evaluated once per step, so its bit always holds last step's outcome.
    logic [NUM_CH-1:0] refr;

    always_ff @(posedge clk) begin
        if (rst) begin
            refr <= '0;
        end else if (start_acc) begin
            refr <= '0;
        end else if (eval_en) begin
            refr[ch_ptr] <= hit;
        end
    end

    assign hit = raw_hit && !refr[ch_ptr];
`else
    assign hit = raw_hit;
`endif

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    // Next-state and evaluation control.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        eval_en   = 1'b0;
        slot_free = !spk.spk_valid || spk.spk_ready;
        last_ch   = (ch_ptr == CH_W'(NUM_CH - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (num_steps == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                eval_en = slot_free;
                if (slot_free && last_ch && (step_cnt == last_step)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Channel/step pointers and the one-deep spike output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_ptr        <= '0;
            step_cnt      <= '0;
            last_step     <= '0;
            spk.spk_valid <= 1'b0;
            spk.spk_ch    <= '0;
            spk.spk_step  <= '0;
        end else begin
            if (start_acc) begin
                ch_ptr    <= '0;
                step_cnt  <= '0;
                last_step <= num_steps - STEP_W'(1);
            end
            if (eval_en) begin
                spk.spk_valid <= hit;
                if (hit) begin
                    spk.spk_ch   <= ch_ptr;
                    spk.spk_step <= step_cnt;
                end
                if (last_ch) begin
                    ch_ptr   <= '0;
                    step_cnt <= (step_cnt == last_step) ? '0 : step_cnt + STEP_W'(1);
                end else begin
                    ch_ptr <= ch_ptr + CH_W'(1);
                end
            end else if (spk.spk_ready) begin
                spk.spk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Directed, table-driven bench for poisson_spike_encoder (NUM_CH=16).
module tb_poisson_spike_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rand_in;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic [15:0] num_steps;
    logic        busy;
    logic        done;

    poisson_spike_encoder_if #(.CH_W(4)) spk_bus ();

    poisson_spike_encoder #(
        .NUM_CH (16),
        .CH_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rand_in   (rand_in),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .num_steps (num_steps),
        .busy      (busy),
        .done      (done),
        .spk       (spk_bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ev_ch[$];
    int ev_step[$];
    int busy_cyc;
    int done_cyc;

`ifdef POISSON_REFRACTORY_EN
    localparam bit REFR = 1'b1;
`else
    localparam bit REFR = 1'b0;
`endif

    typedef struct {
        int ch;
        int inten;
        int rnd;
        int steps;
        int exp_plain;
        int exp_refr;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int val);
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'(ch);
        cfg_data  = 8'(val);
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic clear_all();
        for (int c = 0; c < 16; c++) wr(c, 0);
    endtask

    // Runs one encode; inject_at >= 0 pulses start and a cfg write mid-run.
    task automatic run(input int n, input int stall_len, input int inject_at);
        int  stall_left = 0;
        bit  first      = 1'b0;
        bit  fin        = 1'b0;
        int  cap_ch     = 0;
        int  cap_step   = 0;
        ev_ch.delete();
        ev_step.delete();
        busy_cyc  = 0;
        done_cyc  = 0;
        num_steps = 16'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc == inject_at) begin
                cfg_wr_en = 1'b1;
                cfg_addr  = 4'd5;
                cfg_data  = 8'hFF;
                num_steps = 16'd50;
                start     = 1'b1;
            end else begin
                cfg_wr_en = 1'b0;
                start     = 1'b0;
            end
            if (stall_left > 0) begin
                spk_bus.spk_ready = 1'b0;
                check("stall_valid", int'(spk_bus.spk_valid), 1);
                check("stall_ch", int'(spk_bus.spk_ch), cap_ch);
                check("stall_step", int'(spk_bus.spk_step), cap_step);
                stall_left--;
            end else if (spk_bus.spk_valid && !first && stall_len > 0) begin
                first             = 1'b1;
                cap_ch            = int'(spk_bus.spk_ch);
                cap_step          = int'(spk_bus.spk_step);
                stall_left        = stall_len - 1;
                spk_bus.spk_ready = 1'b0;
            end else begin
                spk_bus.spk_ready = 1'b1;
            end
            if (spk_bus.spk_valid && spk_bus.spk_ready) begin
                ev_ch.push_back(int'(spk_bus.spk_ch));
                ev_step.push_back(int'(spk_bus.spk_step));
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                fin = 1'b1;
            end
            if (!fin) tick();
        end
        spk_bus.spk_ready = 1'b1;
        if (!fin) check("run_timeout", 0, 1);
        tick();
        check("post_done_low", int'(done), 0);
        check("post_busy_low", int'(busy), 0);
    endtask

    task automatic check_events(input string tag, input int exp_n, input int ch, input int stride);
        int n;
        check({tag, "_count"}, ev_ch.size(), exp_n);
        n = (ev_ch.size() < exp_n) ? ev_ch.size() : exp_n;
        for (int j = 0; j < n; j++) begin
            check({tag, "_ch"}, ev_ch[j], ch);
            check({tag, "_step"}, ev_step[j], j * stride);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   stride;
        stride = REFR ? 2 : 1;
        vecs[0] = '{ch: 3,  inten: 255, rnd: 8'h10, steps: 4,  exp_plain: 4, exp_refr: 2};
        vecs[1] = '{ch: 0,  inten: 0,   rnd: 0,     steps: 10, exp_plain: 0, exp_refr: 0};
        vecs[2] = '{ch: 15, inten: 255, rnd: 255,   steps: 2,  exp_plain: 0, exp_refr: 0};
        vecs[3] = '{ch: 7,  inten: 128, rnd: 127,   steps: 3,  exp_plain: 3, exp_refr: 2};
        vecs[4] = '{ch: 7,  inten: 128, rnd: 128,   steps: 3,  exp_plain: 0, exp_refr: 0};
        vecs[5] = '{ch: 9,  inten: 1,   rnd: 0,     steps: 1,  exp_plain: 1, exp_refr: 1};
        vecs[6] = '{ch: 12, inten: 200, rnd: 8'h10, steps: 5,  exp_plain: 5, exp_refr: 3};
        vecs[7] = '{ch: 0,  inten: 255, rnd: 0,     steps: 0,  exp_plain: 0, exp_refr: 0};

        rst               = 1'b1;
        rand_in           = 8'h00;
        cfg_wr_en         = 1'b0;
        cfg_addr          = '0;
        cfg_data          = '0;
        start             = 1'b0;
        num_steps         = '0;
        spk_bus.spk_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(spk_bus.spk_valid), 0);
        check("rst_ch", int'(spk_bus.spk_ch), 0);
        check("rst_step", int'(spk_bus.spk_step), 0);
        rst = 1'b0;
        tick();

        // Single-channel intensity table, spk_ready held high.
        for (int i = 0; i < 8; i++) begin
            clear_all();
            wr(vecs[i].ch, vecs[i].inten);
            rand_in = 8'(vecs[i].rnd);
            run(vecs[i].steps, 0, -1);
            check_events($sformatf("vec%0d", i),
                         REFR ? vecs[i].exp_refr : vecs[i].exp_plain, vecs[i].ch, stride);
            check($sformatf("vec%0d_busy_cycles", i), busy_cyc,
                  (vecs[i].steps == 0) ? 1 : vecs[i].steps * 16 + 2);
            check($sformatf("vec%0d_done_pulses", i), done_cyc, 1);
        end

        // Back-pressure: first event held 5 cycles, scan frozen meanwhile.
        clear_all();
        wr(3, 255);
        rand_in = 8'h10;
        run(4, 5, -1);
        check_events("stall", REFR ? 2 : 4, 3, stride);
        check("stall_busy_cycles", busy_cyc, 4 * 16 + 2 + 5);

        // start and cfg writes while busy have no effect.
        rand_in = 8'h00;
        run(2, 0, 10);
        check_events("ignore", REFR ? 1 : 2, 3, stride);
        check("ignore_busy_cycles", busy_cyc, 2 * 16 + 2);
        run(1, 0, -1);
        check_events("ignore_cfg", 1, 3, stride);

        // Reset during step 2 aborts the run and clears intensities.
        rand_in   = 8'h10;
        num_steps = 16'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (37) tick();
        check("midrun_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        check("midrun_rst_valid", int'(spk_bus.spk_valid), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        rst = 1'b0;
        tick();
        check("midrun_no_done", int'(done), 0);
        rand_in = 8'h00;
        run(1, 0, -1);
        check_events("after_rst", 0, 0, stride);
        check("after_rst_busy_cycles", busy_cyc, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
